f1_light_sequencer: RTL and testbench
=====================================

// Module: f1_light_sequencer
// PURPOSE
//   Sequences the start-light gantry: on a start press, lights NUM_LIGHTS lamps one by one,
//   each after STEP_N timer ticks, holds all lit for a pseudo-random time, then extinguishes all and pulses go.
//   Drives an external delay timer (trigger/N in, time_out back) and owns no counting of its own.
//   Sits between the start/abort buttons and the lamp drivers.
// PARAMETERS
//   NUM_LIGHTS  5      number of lamps (>=2)
//   WIDTH       7      width of delay_n, matches the timer's N port
//   STEP_N      100    ticks between successive lamps (1..2^WIDTH-1)
//   HOLD_MIN    20     minimum all-lit hold, ticks (>=1)
//   HOLD_MASK   8'h3F  mask applied to LFSR value added to HOLD_MIN
// PORTS
//   clk            in   1           system clock
//   rst            in   1           reset, asynchronous, active-low
//   start          in   1           start button (level, synchronised upstream)
//   abort          in   1           false-start/abort (level)
//   time_out       in   1           one-cycle timeout pulse from delay timer
//   delay_trigger  out  1           one-cycle trigger pulse to delay timer
//   delay_n        out  WIDTH       timer load value; stable whenever timer is running
//   lights         out  NUM_LIGHTS  lamp drives, bit 0 = first lamp
//   go             out  1           one-cycle pulse when lamps go out
//   busy           out  1           high from start acceptance until lamps go out or abort
// BEHAVIOUR
//   Reset (rst=0, async): state IDLE, lights=0, go=0, busy=0, delay_trigger=0, delay_n=STEP_N,
//     start_q=0, lamp count=0, LFSR=8'hA5. All outputs registered.
//   States: IDLE, STEP, HOLD, RELEASE (enum in package).
//   IDLE: rising edge of start (start & ~start_q) seen at edge k -> at k+1: delay_trigger=1 (one cycle),
//     delay_n=STEP_N, busy=1, count=0, hold value latched from LFSR, -> STEP. time_out ignored.
//   STEP: on time_out: lights <= {lights[NUM_LIGHTS-2:0],1'b1}, count++. If lights now all 1 ->
//     delay_n=hold, trigger pulse, -> HOLD; else delay_n=STEP_N, trigger pulse, stay STEP.
//     Trigger pulse is in the cycle after time_out; never held >1 cycle.
//   HOLD: on time_out: lights<=0, go=1 for exactly one cycle, busy<=0 -> RELEASE.
//   RELEASE: wait for start==0, then -> IDLE. Start held high never retriggers.
//   abort (STEP or HOLD): next cycle lights=0, busy=0, no go, no trigger, -> RELEASE.
//     abort and time_out same cycle: abort wins. abort in IDLE/RELEASE: no effect.
//   start edges while busy: ignored.
//   Hold arithmetic: hold = HOLD_MIN + (lfsr & HOLD_MASK) computed in WIDTH+1 bits, saturated
//     to 2^WIDTH-1; result 0 forced to 1. delay_n is never 0.
//   LFSR: 8-bit Galois, x^8+x^6+x^5+x^4+1, advances every clock, sampled only on start acceptance.
// CONFIGURATION
//   F1_RANDOM_HOLD_EN defined: hold as above from LFSR.
//   Not defined: LFSR not instantiated; hold = HOLD_MIN constant (saturated as above).
// STRUCTURE
//   Package f1_pkg: state enum typedef, LFSR width/taps/seed constants.
//   Sub-module lfsr_rand (8-bit free-running Galois LFSR, async active-low reset, seed param),
//     instantiated only under F1_RANDOM_HOLD_EN.
//   Bench pairs the block with a behavioural timer model: N-tick countdown after trigger, 1-cycle time_out.
// TESTING
//   1 Reset, start 0->1 -> next cycle delay_trigger=1, delay_n=100, busy=1; successive time_outs ->
//     lights 00001,00011,00111,01111,11111, each followed by a 1-cycle trigger.
//   2 After lights=11111 -> delay_n in [20,83]; time_out -> lights=00000, go=1 one cycle, busy=0.
//   3 start held high through whole sequence -> no second trigger; drop then raise -> new sequence.
//   4 abort at lights=00111 coincident with time_out -> lights=0 next cycle, no go, no trigger.
//   5 rst=0 mid-HOLD -> lights=0, busy=0 immediately (no clock edge needed); release -> IDLE.
//   6 F1_RANDOM_HOLD_EN undefined -> hold delay_n==20 on every run; HOLD_MIN=200,WIDTH=7 -> 127.

Source files
------------

// File: rtl/f1_pkg.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | f1_pkg : shared state encoding and LFSR constants for the start gantry  |
// | Revision: 1.0                                                           |
// +-------------------------------------------------------------------------+
package f1_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_STEP    = 2'd1,
    ST_HOLD    = 2'd2,
    ST_RELEASE = 2'd3
  } f1_state_e;

  localparam int unsigned c_LFSR_WIDTH = 8;
  // Right-shift Galois mask for x^8+x^6+x^5+x^4+1
  localparam logic [7:0]  c_LFSR_TAPS  = 8'hB8;
  localparam logic [7:0]  c_LFSR_SEED  = 8'hA5;

  function automatic logic [7:0] lfsr_next(input logic [7:0] cur);
    lfsr_next = {1'b0, cur[7:1]} ^ (cur[0] ? c_LFSR_TAPS : 8'h00);
  endfunction

endpackage
`default_nettype wire

// File: rtl/lfsr_rand.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | lfsr_rand : free-running 8-bit Galois LFSR, async active-low reset      |
// | Revision: 1.0                                                           |
// +-------------------------------------------------------------------------+
module lfsr_rand
  import f1_pkg::*;
#(
  parameter logic [c_LFSR_WIDTH-1:0] SEED = c_LFSR_SEED
) (
  input  logic                    clk,
  input  logic                    rst,
  output logic [c_LFSR_WIDTH-1:0] rand_o
);

  logic [c_LFSR_WIDTH-1:0] lfsr_q;
  logic [c_LFSR_WIDTH-1:0] lfsr_d;

  always_comb begin
    lfsr_d = lfsr_next(lfsr_q);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lfsr_q <= SEED;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign rand_o = lfsr_q;

endmodule
`default_nettype wire

// File: rtl/f1_light_sequencer.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | f1_light_sequencer : start-light gantry sequencer driving an external   |
// | delay timer. Define F1_RANDOM_HOLD_EN for an LFSR-randomised hold time. |
// | Revision: 1.0                                                           |
// +-------------------------------------------------------------------------+
module f1_light_sequencer
  import f1_pkg::*;
#(
  parameter int unsigned NUM_LIGHTS = 5,
  parameter int unsigned WIDTH      = 7,
  parameter int unsigned STEP_N     = 100,
  parameter int unsigned HOLD_MIN   = 20,
  parameter logic [7:0]  HOLD_MASK  = 8'h3F
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  abort,
  input  logic                  time_out,
  output logic                  delay_trigger,
  output logic [WIDTH-1:0]      delay_n,
  output logic [NUM_LIGHTS-1:0] lights,
  output logic                  go,
  output logic                  busy
);

  localparam int unsigned           c_CNT_W = $clog2(NUM_LIGHTS + 1);
  localparam logic [c_CNT_W-1:0]    c_LAST  = c_CNT_W'(NUM_LIGHTS - 1);
  localparam int unsigned           c_MAX_N = (1 << WIDTH) - 1;
  localparam logic [WIDTH-1:0]      c_STEP  = WIDTH'(STEP_N);

  f1_state_e               state_q, state_d;
  logic                    start_q;
  logic [c_CNT_W-1:0]      count_q, count_d;
  logic [NUM_LIGHTS-1:0]   lights_q, lights_d;
  logic                    go_q, go_d;
  logic                    busy_q, busy_d;
  logic                    trig_q, trig_d;
  logic [WIDTH-1:0]        delay_n_q, delay_n_d;
  logic [WIDTH-1:0]        hold_q, hold_d;

  logic [c_LFSR_WIDTH-1:0] w_rand;
  logic [31:0]             w_hold_sum;
  logic [WIDTH-1:0]        w_hold_n;

`ifdef F1_RANDOM_HOLD_EN
  lfsr_rand #(
    .SEED   (c_LFSR_SEED)
  ) u_lfsr (
    .clk    (clk),
    .rst    (rst),
    .rand_o (w_rand)
  );
`else
  assign w_rand = '0;
`endif

  // Hold is saturated to the timer range and never 0, so the timer always fires
  always_comb begin
    w_hold_sum = 32'(HOLD_MIN) + 32'(w_rand & HOLD_MASK);
    if (w_hold_sum > 32'(c_MAX_N)) begin
      w_hold_n = WIDTH'(c_MAX_N);
    end else begin
      w_hold_n = w_hold_sum[WIDTH-1:0];
    end
    if (w_hold_n == '0) begin
      w_hold_n = WIDTH'(1);
    end
  end

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    lights_d  = lights_q;
    go_d      = 1'b0;
    busy_d    = busy_q;
    trig_d    = 1'b0;
    delay_n_d = delay_n_q;
    hold_d    = hold_q;
    case (state_q)
      ST_IDLE: begin
        if (start && !start_q) begin
          trig_d    = 1'b1;
          delay_n_d = c_STEP;
          busy_d    = 1'b1;
          count_d   = '0;
          hold_d    = w_hold_n;
          state_d   = ST_STEP;
        end
      end
      ST_STEP: begin
        if (abort) begin
          lights_d = '0;
          busy_d   = 1'b0;
          state_d  = ST_RELEASE;
        end else if (time_out) begin
          lights_d = {lights_q[NUM_LIGHTS-2:0], 1'b1};
          count_d  = count_q + c_CNT_W'(1);
          trig_d   = 1'b1;
          if (count_q == c_LAST) begin
            delay_n_d = hold_q;
            state_d   = ST_HOLD;
          end else begin
            delay_n_d = c_STEP;
          end
        end
      end
      ST_HOLD: begin
        if (abort) begin
          lights_d = '0;
          busy_d   = 1'b0;
          state_d  = ST_RELEASE;
        end else if (time_out) begin
          lights_d = '0;
          go_d     = 1'b1;
          busy_d   = 1'b0;
          state_d  = ST_RELEASE;
        end
      end
      ST_RELEASE: begin
        // A held start button must be let go before another run can begin
        if (!start) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      start_q   <= 1'b0;
      count_q   <= '0;
      lights_q  <= '0;
      go_q      <= 1'b0;
      busy_q    <= 1'b0;
      trig_q    <= 1'b0;
      delay_n_q <= c_STEP;
      hold_q    <= c_STEP;
    end else begin
      state_q   <= state_d;
      start_q   <= start;
      count_q   <= count_d;
      lights_q  <= lights_d;
      go_q      <= go_d;
      busy_q    <= busy_d;
      trig_q    <= trig_d;
      delay_n_q <= delay_n_d;
      hold_q    <= hold_d;
    end
  end

  assign delay_trigger = trig_q;
  assign delay_n       = delay_n_q;
  assign lights        = lights_q;
  assign go            = go_q;
  assign busy          = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_f1_light_sequencer.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | tb_f1_light_sequencer : directed bench with behavioural delay timers    |
// | Revision: 1.0                                                           |
// +-------------------------------------------------------------------------+
module tb_f1_light_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic       time_out = 1'b0;
  logic       delay_trigger;
  logic [6:0] delay_n;
  logic [4:0] lights;
  logic       go;
  logic       busy;

  logic       start2 = 1'b0;
  logic       abort2 = 1'b0;
  logic       to2 = 1'b0;
  logic       trig2;
  logic [6:0] dn2;
  logic [1:0] lt2;
  logic       go2;
  logic       busy2;

  logic [7:0] tmr_cnt = 8'd0;
  logic [7:0] tmr2_cnt = 8'd0;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  f1_light_sequencer #(
    .NUM_LIGHTS (5),
    .WIDTH      (7),
    .STEP_N     (100),
    .HOLD_MIN   (20),
    .HOLD_MASK  (8'h3F)
  ) u_dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .abort         (abort),
    .time_out      (time_out),
    .delay_trigger (delay_trigger),
    .delay_n       (delay_n),
    .lights        (lights),
    .go            (go),
    .busy          (busy)
  );

  f1_light_sequencer #(
    .NUM_LIGHTS (2),
    .WIDTH      (7),
    .STEP_N     (3),
    .HOLD_MIN   (200),
    .HOLD_MASK  (8'h3F)
  ) u_sat (
    .clk           (clk),
    .rst           (rst),
    .start         (start2),
    .abort         (abort2),
    .time_out      (to2),
    .delay_trigger (trig2),
    .delay_n       (dn2),
    .lights        (lt2),
    .go            (go2),
    .busy          (busy2)
  );

  // Behavioural delay timers: load N on trigger, pulse time_out N ticks later
  always @(posedge clk) begin
    if (delay_trigger) begin
      tmr_cnt  <= {1'b0, delay_n};
      time_out <= 1'b0;
    end else if (tmr_cnt != 8'd0) begin
      tmr_cnt  <= tmr_cnt - 8'd1;
      time_out <= (tmr_cnt == 8'd1);
    end else begin
      time_out <= 1'b0;
    end
  end

  always @(posedge clk) begin
    if (trig2) begin
      tmr2_cnt <= {1'b0, dn2};
      to2      <= 1'b0;
    end else if (tmr2_cnt != 8'd0) begin
      tmr2_cnt <= tmr2_cnt - 8'd1;
      to2      <= (tmr2_cnt == 8'd1);
    end else begin
      to2 <= 1'b0;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic check_hold(input logic [6:0] val);
`ifdef F1_RANDOM_HOLD_EN
    chk("hold_range", 32'((val >= 7'd20) && (val <= 7'd83)), 32'd1);
`else
    chk("hold_const", 32'(val), 32'd20);
`endif
  endtask

  task automatic wait_to(input bit which);
    bit seen = 1'b0;
    for (int n = 0; n < 300 && !seen; n++) begin
      @(negedge clk);
      seen = which ? to2 : time_out;
    end
    if (!seen) chk("timeout_wait", 32'd0, 32'd1);
  endtask

  task automatic start_seq();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    chk("start_trig", 32'(delay_trigger), 32'd1);
    chk("start_n", 32'(delay_n), 32'd100);
    chk("start_busy", 32'(busy), 32'd1);
    chk("start_lights", 32'(lights), 32'd0);
    @(negedge clk);
    chk("start_trig_1cyc", 32'(delay_trigger), 32'd0);
  endtask

  task automatic run_lamps();
    for (int i = 0; i < 5; i++) begin
      wait_to(1'b0);
      @(negedge clk);
      chk("lamp", 32'(lights), (32'd1 << (i + 1)) - 32'd1);
      chk("lamp_trig", 32'(delay_trigger), 32'd1);
      chk("lamp_go", 32'(go), 32'd0);
      if (i < 4) chk("step_n", 32'(delay_n), 32'd100);
      else       check_hold(delay_n);
      @(negedge clk);
      chk("lamp_trig_1cyc", 32'(delay_trigger), 32'd0);
    end
  endtask

  task automatic finish_hold();
    wait_to(1'b0);
    @(negedge clk);
    chk("go_lights", 32'(lights), 32'd0);
    chk("go_pulse", 32'(go), 32'd1);
    chk("go_busy", 32'(busy), 32'd0);
    chk("go_trig", 32'(delay_trigger), 32'd0);
    @(negedge clk);
    chk("go_1cyc", 32'(go), 32'd0);
  endtask

  initial begin
    bit trig_seen;
    bit go_seen;

    @(negedge clk);
    chk("rst_lights", 32'(lights), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_go", 32'(go), 32'd0);
    chk("rst_trig", 32'(delay_trigger), 32'd0);
    chk("rst_n", 32'(delay_n), 32'd100);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // Full sequence with start held high throughout
    start_seq();
    run_lamps();
    finish_hold();
    trig_seen = 1'b0;
    repeat (20) begin
      @(negedge clk);
      trig_seen |= delay_trigger;
    end
    chk("held_no_retrig", 32'(trig_seen), 32'd0);
    chk("held_not_busy", 32'(busy), 32'd0);
    start = 1'b0;
    repeat (2) @(negedge clk);

    // Abort coincident with the time_out that would light lamp 4
    start_seq();
    for (int i = 0; i < 3; i++) begin
      wait_to(1'b0);
      @(negedge clk);
      chk("abort_lamp", 32'(lights), (32'd1 << (i + 1)) - 32'd1);
    end
    wait_to(1'b0);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_lights", 32'(lights), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_go", 32'(go), 32'd0);
    chk("abort_trig", 32'(delay_trigger), 32'd0);
    trig_seen = 1'b0;
    go_seen   = 1'b0;
    repeat (10) begin
      @(negedge clk);
      trig_seen |= delay_trigger;
      go_seen   |= go;
    end
    chk("abort_quiet_trig", 32'(trig_seen), 32'd0);
    chk("abort_quiet_go", 32'(go_seen), 32'd0);
    start = 1'b0;
    repeat (2) @(negedge clk);

    // Asynchronous reset in the middle of HOLD
    start_seq();
    run_lamps();
    start = 1'b0;
    #2 rst = 1'b0;
    #1;
    chk("arst_lights", 32'(lights), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_n", 32'(delay_n), 32'd100);
    @(negedge clk);
    rst = 1'b1;
    trig_seen = 1'b0;
    go_seen   = 1'b0;
    repeat (100) begin
      @(negedge clk);
      trig_seen |= delay_trigger;
      go_seen   |= go;
    end
    chk("arst_quiet_trig", 32'(trig_seen), 32'd0);
    chk("arst_quiet_go", 32'(go_seen), 32'd0);
    start_seq();
    run_lamps();
    finish_hold();
    start = 1'b0;

    // Two-lamp instance whose hold saturates at the timer maximum
    @(negedge clk);
    start2 = 1'b1;
    @(negedge clk);
    chk("sat_trig", 32'(trig2), 32'd1);
    chk("sat_step_n", 32'(dn2), 32'd3);
    for (int i = 0; i < 2; i++) begin
      wait_to(1'b1);
      @(negedge clk);
      chk("sat_lamp", 32'(lt2), (32'd1 << (i + 1)) - 32'd1);
      chk("sat_lamp_trig", 32'(trig2), 32'd1);
      if (i == 1) chk("sat_hold", 32'(dn2), 32'd127);
    end
    wait_to(1'b1);
    @(negedge clk);
    chk("sat_go", 32'(go2), 32'd1);
    chk("sat_busy", 32'(busy2), 32'd0);
    start2 = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
